// File: rtl/rv32i_pkg.sv
// Shared constants, types and helpers for the RV32I instruction-fetch front end.
package rv32i_pkg;

    localparam int              XLEN              = 32;
    localparam logic [XLEN-1:0] RESET_VEC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR         = 32'h0000_0013;  // addi x0, x0, 0

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    // Named view of the fetch state encoding, handy for casts in waveforms.
    typedef enum logic [1:0] {
        ST_REQ  = S_REQ,
        ST_WAIT = S_WAIT,
        ST_DROP = S_DROP
    } ifetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            misalign;
    } fetch_pkt_t;

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] cur);
        return cur + XLEN'(4);
    endfunction

endpackage

// File: rtl/rv32i_fifo.sv
// Small synchronous FIFO with flush; the head entry is read straight from the storage registers.
module rv32i_fifo
    import rv32i_pkg::*;
#(
    parameter type T     = fetch_pkt_t,
    parameter int  DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  T              push_data,
    input  logic          pop,
    input  logic          flush,
    output T              pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: storage has no reset; pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/rv32i_ifetch.sv
// Fetch front end: owns the PC, issues one imem read at a time and buffers {pc, instr} for decode.
// Optional feature macro: RV32I_IFETCH_MISALIGN_EN (misaligned redirect targets become fault packets).
module rv32i_ifetch
    import rv32i_pkg::*;
#(
    parameter int              DEPTH     = 2,
    parameter logic [XLEN-1:0] RESET_VEC = RESET_VEC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic            if_misalign
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]      state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] redirect_tgt;
    logic            armed;
    logic            halt;
    logic            mis_push;
    logic            req_fire;
    logic            outstanding;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_empty;
    logic            unused_full;
    logic [CW-1:0]   fifo_count;
    fetch_pkt_t      push_pkt;
    fetch_pkt_t      head_pkt;

    // armed keeps the request low until the first clock after reset is released.
    assign imem_req_valid = armed & ~rst & ~halt & en & (state == S_REQ) & (fifo_count < CW'(DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    // A read is still owed after this edge unless its response is landing right now.
    assign outstanding = req_fire | ((state != S_REQ) & ~imem_rsp_valid);

`ifdef RV32I_IFETCH_MISALIGN_EN
    logic tgt_misalign;

    assign redirect_tgt = redirect_pc;
    assign tgt_misalign = (redirect_pc[1:0] != 2'b00);
    assign if_misalign  = head_pkt.misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt     <= 1'b0;
            mis_push <= 1'b0;
        end else if (redirect) begin
            halt     <= tgt_misalign;
            mis_push <= tgt_misalign;
        end else begin
            mis_push <= 1'b0;
        end
    end
`else
    logic unused_bits;

    assign unused_bits  = ^{redirect_pc[1:0], head_pkt.misalign, NOP_INSTR};
    assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};
    assign halt         = 1'b0;
    assign mis_push     = 1'b0;
    assign if_misalign  = 1'b0;
`endif

    always_comb begin
        // NOTE: defaults first so no path through this block can infer a latch.
        push_pkt  = '{pc: req_pc, instr: imem_rsp_data, misalign: 1'b0};
        fifo_push = (state == S_WAIT) & imem_rsp_valid & ~redirect;
        if (mis_push) begin
            push_pkt  = '{pc: pc, instr: NOP_INSTR, misalign: 1'b1};
            fifo_push = 1'b1;
        end
    end

    assign fifo_pop = if_ready & ~fifo_empty;
    assign if_valid = ~fifo_empty;
    assign if_pc    = head_pkt.pc;
    assign if_instr = head_pkt.instr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_REQ;
            pc     <= RESET_VEC;
            req_pc <= RESET_VEC;
            armed  <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (req_fire) req_pc <= pc;
            if (redirect) begin
                pc    <= redirect_tgt;
                state <= outstanding ? S_DROP : S_REQ;
            end else begin
                case (state)
                    S_REQ: begin
                        if (req_fire) begin
                            pc    <= next_pc(pc);
                            state <= S_WAIT;
                        end
                    end
                    S_WAIT, S_DROP: begin
                        if (imem_rsp_valid) state <= S_REQ;
                    end
                    default: state <= S_REQ;
                endcase
            end
        end
    end

    rv32i_fifo #(
        .T     (fetch_pkt_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_pkt),
        .pop       (fifo_pop),
        .flush     (redirect),
        .pop_data  (head_pkt),
        .full      (unused_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_rv32i_ifetch.sv
// Directed bench for rv32i_ifetch with a behavioural imem of configurable response latency.
module tb_rv32i_ifetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_misalign;

    int          total = 0;
    int          bad   = 0;
    int          lat   = 1;
    int          cnt   = 0;
    logic [31:0] pend_addr = '0;

    always #5 clk = ~clk;

    rv32i_ifetch dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_misalign    (if_misalign)
    );

    // Memory image: every word holds its own address tagged with 0xC0DE in the upper half.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hC0DE_0000 | a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock: sample the request at the falling edge, then play imem just after the rising edge.
    task automatic tick();
        logic        fire;
        logic [31:0] a;
        @(negedge clk);
        fire = imem_req_valid & imem_req_ready;
        a    = imem_req_addr;
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        if (fire) begin
            pend_addr = a;
            cnt       = lat;
        end
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = word_at(pend_addr);
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst            = 1'b1;
        redirect       = 1'b0;
        imem_rsp_valid = 1'b0;
        cnt            = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        en             = 1'b1;
        redirect       = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if_ready       = 1'b1;

        // Reset state and first issue after release
        #2;
        check_bit("rst_req_valid", imem_req_valid, 1'b0);
        check_bit("rst_if_valid", if_valid, 1'b0);
        check("rst_req_addr", imem_req_addr, 32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_bit("prearm_req_valid", imem_req_valid, 1'b0);
        @(posedge clk);
        #1;
        check_bit("t1_req0_valid", imem_req_valid, 1'b1);
        check("t1_req0_addr", imem_req_addr, 32'h0000_0000);

        // Test 1: steady stream, one request every two cycles
        tick();
        check_bit("t1_wait_req", imem_req_valid, 1'b0);
        check_bit("t1_wait_ifv", if_valid, 1'b0);
        tick();
        check_bit("t1_pkt0_valid", if_valid, 1'b1);
        check("t1_pkt0_pc", if_pc, 32'h0000_0000);
        check("t1_pkt0_instr", if_instr, 32'hC0DE_0000);
        check("t1_req4_addr", imem_req_addr, 32'h0000_0004);
        tick();
        check_bit("t1_empty", if_valid, 1'b0);
        tick();
        check("t1_pkt4_pc", if_pc, 32'h0000_0004);
        check("t1_pkt4_instr", if_instr, 32'hC0DE_0004);
        check("t1_req8_addr", imem_req_addr, 32'h0000_0008);

        // Test 2: decode stalls, FIFO fills and issuing stops
        if_ready = 1'b0;
        pulse_reset();
        repeat (4) tick();
        check_bit("t2_full_req", imem_req_valid, 1'b0);
        check("t2_head_pc", if_pc, 32'h0000_0000);
        tick();
        check_bit("t2_hold_req", imem_req_valid, 1'b0);
        check("t2_hold_instr", if_instr, 32'hC0DE_0000);
        if_ready = 1'b1;
        tick();
        check_bit("t2_resume_req", imem_req_valid, 1'b1);
        check("t2_resume_addr", imem_req_addr, 32'h0000_0008);
        check("t2_second_pc", if_pc, 32'h0000_0004);
        tick();
        tick();
        check("t2_pkt8_pc", if_pc, 32'h0000_0008);
        check("t2_pkt8_instr", if_instr, 32'hC0DE_0008);

        // Test 3: redirect while waiting on the read for 0x8
        lat = 2;
        pulse_reset();
        repeat (7) tick();
        check_bit("t3_waiting", imem_req_valid, 1'b0);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        check_bit("t3_drop_req", imem_req_valid, 1'b0);
        tick();
        check_bit("t3_dropped_ifv", if_valid, 1'b0);
        check_bit("t3_new_req", imem_req_valid, 1'b1);
        check("t3_new_addr", imem_req_addr, 32'h0000_0100);
        repeat (3) tick();
        check("t3_pkt_pc", if_pc, 32'h0000_0100);
        check("t3_pkt_instr", if_instr, 32'hC0DE_0100);

        // Test 4: redirect coinciding with a pop and a request handshake
        lat = 1;
        pulse_reset();
        repeat (2) tick();
        check_bit("t4_pre_ifv", if_valid, 1'b1);
        check_bit("t4_pre_req", imem_req_valid, 1'b1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        tick();
        redirect = 1'b0;
        check_bit("t4_flushed", if_valid, 1'b0);
        check_bit("t4_drop_req", imem_req_valid, 1'b0);
        check("t4_drop_addr", imem_req_addr, 32'h0000_0040);
        tick();
        check_bit("t4_no_stale", if_valid, 1'b0);
        check_bit("t4_req40", imem_req_valid, 1'b1);
        repeat (2) tick();
        check("t4_pkt_pc", if_pc, 32'h0000_0040);
        check("t4_pkt_instr", if_instr, 32'hC0DE_0040);

        // Test 5: reset while a read is outstanding; its late response must be ignored
        lat      = 2;
        if_ready = 1'b0;
        pulse_reset();
        repeat (3) tick();
        check_bit("t5_pre_ifv", if_valid, 1'b1);
        tick();
        rst = 1'b1;
        #1;
        check_bit("t5_rst_req", imem_req_valid, 1'b0);
        check_bit("t5_rst_ifv", if_valid, 1'b0);
        tick();
        rst      = 1'b0;
        if_ready = 1'b1;
        #1;
        check_bit("t5_prearm", imem_req_valid, 1'b0);
        tick();
        check_bit("t5_stale_ifv", if_valid, 1'b0);
        check_bit("t5_req_valid", imem_req_valid, 1'b1);
        check("t5_req_addr", imem_req_addr, 32'h0000_0000);
        repeat (3) tick();
        check("t5_pkt_pc", if_pc, 32'h0000_0000);
        check("t5_pkt_instr", if_instr, 32'hC0DE_0000);

        lat = 1;
`ifdef RV32I_IFETCH_MISALIGN_EN
        // Test 6: misaligned target produces one fault packet and halts issuing
        pulse_reset();
        en          = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        tick();
        redirect = 1'b0;
        en       = 1'b1;
        #1;
        check_bit("t6_no_req", imem_req_valid, 1'b0);
        tick();
        check_bit("t6_pkt_valid", if_valid, 1'b1);
        check("t6_pkt_pc", if_pc, 32'h0000_0102);
        check("t6_pkt_instr", if_instr, 32'h0000_0013);
        check_bit("t6_pkt_mis", if_misalign, 1'b1);
        check_bit("t6_halt_req", imem_req_valid, 1'b0);
        tick();
        check_bit("t6_popped", if_valid, 1'b0);
        check_bit("t6_still_halt", imem_req_valid, 1'b0);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        #1;
        check_bit("t6_resume_req", imem_req_valid, 1'b1);
        check("t6_resume_addr", imem_req_addr, 32'h0000_0200);
        repeat (2) tick();
        check("t6_pkt200_instr", if_instr, 32'hC0DE_0200);
        check_bit("t6_pkt200_mis", if_misalign, 1'b0);
`else
        // Test 6 (feature off): low target bits are cleared, no fault packet
        pulse_reset();
        en          = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        tick();
        redirect = 1'b0;
        en       = 1'b1;
        #1;
        check_bit("t6_req_valid", imem_req_valid, 1'b1);
        check("t6_aligned_addr", imem_req_addr, 32'h0000_0100);
        repeat (2) tick();
        check("t6_pkt_pc", if_pc, 32'h0000_0100);
        check("t6_pkt_instr", if_instr, 32'hC0DE_0100);
        check_bit("t6_pkt_mis", if_misalign, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
